gpu_sprite_line_renderer: RTL and testbench
===========================================

Name: gpu_sprite_line_renderer

Overview:
- Sits directly downstream of the GPU sprite-table processor.
- Consumes its packed per-level sprite arrays (id/x/y/color), plus the VGA controller's h_pos/v_pos.
- During horizontal blanking, scans all sprite levels and builds a short list of the sprites that hit the next scanline.
- During active video, outputs the top-priority sprite pixel (color, id, valid) for the pixel mixer.

Parameters:
- NUM_SPRITES, 64: sprite levels in the input arrays; level NUM_SPRITES-1 has the highest priority.
- MAX_LINE_SPRITES, 8: line-list capacity (sprites drawable on one scanline).
- SPRITE_W, 16: sprite width in pixels.
- SPRITE_H, 16: sprite height in pixels.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines.
- V_TOTAL, 525: total lines per frame, including blanking.
- SCAN_START, 640: h_pos value that triggers the line scan.

Ports:
- clk  in  1  system clock (50 MHz; h_pos advances every 2 clk).
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- h_pos  in  10  current VGA column.
- v_pos  in  10  current VGA line.
- sprite_id_in  in  6*NUM_SPRITES  packed ids; level k occupies [(k+1)*6-1 : k*6].
- sprite_x_in  in  10*NUM_SPRITES  packed left x per level.
- sprite_y_in  in  10*NUM_SPRITES  packed top y per level.
- sprite_color_in  in  16*NUM_SPRITES  packed RGB565 per level; 16'h0000 = slot disabled.
- pixel_valid  out  1  a sprite covers the current pixel.
- pixel_color  out  16  color of the winning sprite, else 0.
- pixel_sprite_id  out  6  id of the winning sprite, else 0.
- scan_busy  out  1  high while in SCAN state.
- line_sprite_count  out  $clog2(MAX_LINE_SPRITES+1)  entries in the current line list.

Behaviour:
- Reset (rst==0 at clk edge):
  - state=IDLE; list count=0; h_prev=0.
  - All outputs 0.
  - Reset mid-scan abandons the scan; the following line shows no sprites.
- Scan trigger: h_pos==SCAN_START && h_prev!=SCAN_START, where h_prev is h_pos registered each clk (edge detect; h_pos holds for 2 clk).
- Target line: tgt = (v_pos==V_TOTAL-1) ? 0 : v_pos+1.
- Trigger actions:
  - Snapshot all four input arrays into internal registers.
  - Clear the list count; idx=NUM_SPRITES-1.
  - state IDLE->SCAN.
- Trigger while in SCAN or DONE: ignored.
- SCAN, one level per clk:
  - Hit if color!=0 && tgt>=y && tgt<y+SPRITE_H.
  - Compare in 11-bit unsigned, so y+SPRITE_H never wraps.
  - On a hit with count<MAX_LINE_SPRITES: store {id,x,color} at entry[count]; count++.
  - Hit when full: dropped (lower levels lose).
  - idx decrements each clk. After idx==0 is processed, SCAN->DONE.
  - Scan takes exactly NUM_SPRITES clk (64 clk, inside the 320-clk blanking).
- DONE->IDLE when h_pos==0 (new line begins). The list remains valid for the whole line.
- line_sprite_count reflects the count register continuously.
- Priority: entry 0 holds the highest level. Entries are therefore already in priority order; the lowest matching entry index wins.
- Pixel path, 1 clk registered latency from h_pos:
  - If h_pos<H_ACTIVE && v_pos<V_ACTIVE && state!=SCAN, find the lowest e<count with h_pos>=x_e && h_pos<x_e+SPRITE_W (11-bit).
  - On a match: pixel_valid=1, pixel_color=color_e, pixel_sprite_id=id_e.
  - Otherwise all three are 0.
- Blanking (h_pos>=H_ACTIVE or v_pos>=V_ACTIVE): outputs 0.
- Last line: the scan on line V_TOTAL-1 prepares line 0. The list built on line V_ACTIVE-1 is never displayed.
- Sprites with x>=H_ACTIVE: never match. Sprites partially past the right edge are clipped naturally.

Optional Feature:
- Macro: GPU_SPRITE_OVERFLOW_EN.
- When defined:
  - Adds output sprite_overflow (1 bit).
  - Set when a hit is dropped because the list is full during SCAN.
  - Held until the next scan trigger, which clears it; reset clears it.
  - Adds a second output frame_overflow, sticky across a frame and cleared when v_pos returns to 0 at h_pos==0.
- When undefined: both ports and all associated logic are absent. Dropping behaviour is unchanged.

Test Plan:
- Reset: hold rst=0 for 4 clk mid-scan, release -> scan_busy=0, line_sprite_count=0, pixel_valid=0 on the next active line.
- Single sprite: level 63 at x=150, y=162, color 16'hFFFF, id 0, others color 0 -> on line 162, pixel_valid=1 with color FFFF for h_pos 150..165 (1 clk late), 0 at h_pos 149 and 166; line 178 has no pixels.
- Priority overlap: level 62 (red F800, x=182) and level 60 (blue 001F, x=190), both y=50 -> on line 50, h 182..197 red; 198..205 blue; h 190..197 red (higher level wins).
- Overflow: 10 enabled levels 63..54 all at y=100 -> line_sprite_count=8; levels 55 and 54 never drawn; sprite_overflow=1 with GPU_SPRITE_OVERFLOW_EN.
- Snapshot: change sprite_x_in during the active part of line 200 -> line 200 output is unaffected; the new x appears on line 201.
- Wrap: sprite y=0 -> scan at v_pos=524 yields count=1; pixels are drawn on line 0 of the next frame.

Source files
------------

// File: rtl/gpu_sprite_line_renderer.sv
// Scanline sprite renderer: builds a per-line sprite list during horizontal blanking and
// emits the top-priority sprite pixel during active video. Optional: GPU_SPRITE_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for the scan trigger at h_pos==SCAN_START
// SCAN  | walking one sprite level per clk, highest level first
// DONE  | list complete, held for display until h_pos returns to 0
module gpu_sprite_line_renderer #(
    parameter int NUM_SPRITES      = 64,
    parameter int MAX_LINE_SPRITES = 8,
    parameter int SPRITE_W         = 16,
    parameter int SPRITE_H         = 16,
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int V_TOTAL          = 525,
    parameter int SCAN_START       = 640
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [9:0]                                h_pos,
    input  logic [9:0]                                v_pos,
    input  logic [6*NUM_SPRITES-1:0]                  sprite_id_in,
    input  logic [10*NUM_SPRITES-1:0]                 sprite_x_in,
    input  logic [10*NUM_SPRITES-1:0]                 sprite_y_in,
    input  logic [16*NUM_SPRITES-1:0]                 sprite_color_in,
    output logic                                      pixel_valid,
    output logic [15:0]                               pixel_color,
    output logic [5:0]                                pixel_sprite_id,
    output logic                                      scan_busy,
    output logic [$clog2(MAX_LINE_SPRITES+1)-1:0]     line_sprite_count
`ifdef GPU_SPRITE_OVERFLOW_EN
    ,
    output logic                                      sprite_overflow,
    output logic                                      frame_overflow
`endif
);
    localparam int CW = $clog2(MAX_LINE_SPRITES + 1);
    localparam int EW = $clog2(MAX_LINE_SPRITES);
    localparam int IW = $clog2(NUM_SPRITES);
    localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    SCAN_POS = 10'(SCAN_START);
    localparam logic [10:0]   SW11     = 11'(SPRITE_W);
    localparam logic [10:0]   SH11     = 11'(SPRITE_H);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_LINE_SPRITES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [9:0]        h_prev;
    logic [9:0]        tgt;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;

    logic [6*NUM_SPRITES-1:0]  snap_id;
    logic [10*NUM_SPRITES-1:0] snap_x;
    logic [10*NUM_SPRITES-1:0] snap_y;
    logic [16*NUM_SPRITES-1:0] snap_color;

    logic [5:0]  ent_id    [MAX_LINE_SPRITES];
    logic [9:0]  ent_x     [MAX_LINE_SPRITES];
    logic [15:0] ent_color [MAX_LINE_SPRITES];

    logic        trigger;
    logic [9:0]  cur_y;
    logic [15:0] cur_color;
    logic        hit;
    logic        room;
    logic        active;
    logic        match;
    logic [15:0] match_color;
    logic [5:0]  match_id;

    assign trigger   = (h_pos == SCAN_POS) && (h_prev != SCAN_POS);
    assign cur_y     = snap_y[idx*10 +: 10];
    assign cur_color = snap_color[idx*16 +: 16];
    // 11-bit compare so a sprite near y=1023 cannot wrap around to the top
    assign hit       = (cur_color != 16'h0000) &&
                       ({1'b0, tgt} >= {1'b0, cur_y}) &&
                       ({1'b0, tgt} <  ({1'b0, cur_y} + SH11));
    assign room      = (cnt < CNT_MAX);
    assign active    = (h_pos < H_ACT) && (v_pos < V_ACT) && (state != SCAN);

    // Entries are stored highest level first, so the lowest matching index wins.
    always_comb begin
        match       = 1'b0;
        match_color = 16'h0000;
        match_id    = 6'd0;
        for (int e = MAX_LINE_SPRITES - 1; e >= 0; e--) begin
            if ((CW'(e) < cnt) &&
                ({1'b0, h_pos} >= {1'b0, ent_x[e]}) &&
                ({1'b0, h_pos} <  ({1'b0, ent_x[e]} + SW11))) begin
                match       = 1'b1;
                match_color = ent_color[e];
                match_id    = ent_id[e];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            h_prev          <= 10'd0;
            tgt             <= 10'd0;
            idx             <= '0;
            cnt             <= '0;
            pixel_valid     <= 1'b0;
            pixel_color     <= 16'h0000;
            pixel_sprite_id <= 6'd0;
`ifdef GPU_SPRITE_OVERFLOW_EN
            sprite_overflow <= 1'b0;
            frame_overflow  <= 1'b0;
`endif
        end else begin
            h_prev          <= h_pos;
            pixel_valid     <= active && match;
            pixel_color     <= (active && match) ? match_color : 16'h0000;
            pixel_sprite_id <= (active && match) ? match_id : 6'd0;
`ifdef GPU_SPRITE_OVERFLOW_EN
            if (v_pos == 10'd0 && h_pos == 10'd0)
                frame_overflow <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= SCAN;
                        cnt   <= '0;
                        idx   <= IW'(NUM_SPRITES - 1);
                        tgt   <= (v_pos == V_LAST) ? 10'd0 : v_pos + 10'd1;
`ifdef GPU_SPRITE_OVERFLOW_EN
                        sprite_overflow <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (hit && room)
                        cnt <= cnt + 1'b1;
`ifdef GPU_SPRITE_OVERFLOW_EN
                    if (hit && !room) begin
                        sprite_overflow <= 1'b1;
                        frame_overflow  <= 1'b1;
                    end
`endif
                    idx <= idx - 1'b1;
                    if (idx == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (h_pos == 10'd0)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data storage needs no reset: it is only ever read below the count register.
    always_ff @(posedge clk) begin
        if (rst && state == IDLE && trigger) begin
            snap_id    <= sprite_id_in;
            snap_x     <= sprite_x_in;
            snap_y     <= sprite_y_in;
            snap_color <= sprite_color_in;
        end
        if (rst && state == SCAN && hit && room) begin
            ent_id[cnt[EW-1:0]]    <= snap_id[idx*6 +: 6];
            ent_x[cnt[EW-1:0]]     <= snap_x[idx*10 +: 10];
            ent_color[cnt[EW-1:0]] <= cur_color;
        end
    end

    assign scan_busy         = (state == SCAN);
    assign line_sprite_count = cnt;

endmodule

// File: tb/tb_gpu_sprite_line_renderer.sv
// Self-checking bench for gpu_sprite_line_renderer: directed vector table plus randomized
// sprite tables checked against a per-line list model.
module tb_gpu_sprite_line_renderer;
    localparam int NS = 64;
    localparam int ML = 8;
    localparam int SW = 16;
    localparam int SH = 16;
    localparam int HA = 640;
    localparam int VA = 480;
    localparam int VT = 525;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        h_pos, v_pos;
    logic [6*NS-1:0]   spr_id;
    logic [10*NS-1:0]  spr_x;
    logic [10*NS-1:0]  spr_y;
    logic [16*NS-1:0]  spr_c;
    logic              pixel_valid;
    logic [15:0]       pixel_color;
    logic [5:0]        pixel_sprite_id;
    logic              scan_busy;
    logic [3:0]        line_sprite_count;
`ifdef GPU_SPRITE_OVERFLOW_EN
    logic              sprite_overflow;
    logic              frame_overflow;
`endif
    logic [22:0]       dut_pix;

    gpu_sprite_line_renderer dut (
        .clk(clk), .rst(rst), .h_pos(h_pos), .v_pos(v_pos),
        .sprite_id_in(spr_id), .sprite_x_in(spr_x), .sprite_y_in(spr_y),
        .sprite_color_in(spr_c),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color),
        .pixel_sprite_id(pixel_sprite_id), .scan_busy(scan_busy),
        .line_sprite_count(line_sprite_count)
`ifdef GPU_SPRITE_OVERFLOW_EN
        , .sprite_overflow(sprite_overflow), .frame_overflow(frame_overflow)
`endif
    );

    always #5 clk = ~clk;
    assign dut_pix = {pixel_valid, pixel_color, pixel_sprite_id};

    typedef struct {int x; logic [15:0] c; logic [5:0] id;} ent_t;
    typedef struct {int scen; int line; int h; logic ev; logic [15:0] ec; logic [5:0] eid;} vec_t;

    ent_t        m_list[$];
    ent_t        nl[$];
    bit          novf, m_sovf, m_fovf;
    logic [22:0] rec [HA];
    vec_t        vecs [23];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input int v, input int h,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s line=%0d h/k=%0d: got %0h expected %0h", name, v, h, act, exp);
        end
    endtask

    // Reference list: walk levels high to low, keep the first ML that cover the target line.
    task automatic build(input int tgt);
        nl = {};
        novf = 1'b0;
        for (int k = NS - 1; k >= 0; k--) begin
            int y;
            logic [15:0] c;
            y = int'(spr_y[k*10 +: 10]);
            c = spr_c[k*16 +: 16];
            if (c != 16'h0 && tgt >= y && tgt < y + SH) begin
                if (nl.size() < ML) nl.push_back('{int'(spr_x[k*10 +: 10]), c, spr_id[k*6 +: 6]});
                else novf = 1'b1;
            end
        end
    endtask

    function automatic logic [22:0] model_pix(input int h, input int v);
        if (h < HA && v < VA)
            foreach (m_list[e])
                if (h >= m_list[e].x && h < m_list[e].x + SW)
                    return {1'b1, m_list[e].c, m_list[e].id};
        return 23'd0;
    endfunction

    task automatic clear_sprites();
        spr_id = '0; spr_x = '0; spr_y = '0; spr_c = '0;
    endtask

    task automatic set_sprite(input int lvl, input int id, input int x, input int y, input logic [15:0] c);
        spr_id[lvl*6 +: 6]  = 6'(id);
        spr_x[lvl*10 +: 10] = 10'(x);
        spr_y[lvl*10 +: 10] = 10'(y);
        spr_c[lvl*16 +: 16] = c;
    endtask

    task automatic set_random(input int tgt);
        for (int k = 0; k < NS; k++) begin
            int yy;
            yy = tgt - 16 + int'($urandom_range(0, 24));
            if (yy < 0) yy = 0;
            set_sprite(k, int'($urandom_range(0, 63)), int'($urandom_range(0, 700)), yy,
                       ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)));
        end
    endtask

    // mode: 0 normal, 1 reset mid-scan, 2 scramble inputs mid-scan, 3 move level 63 to x=330 mid-line
    task automatic run_line(input int v, input int mode);
        int k, tgt;
        v_pos = 10'(v);
        if (v == 0) m_fovf = 1'b0;
        for (int h = 0; h < HA; h++) begin
            if (mode == 3 && h == 100) spr_x[63*10 +: 10] = 10'd330;
            h_pos = 10'(h);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                chk("pixel", v, h, 32'(dut_pix), 32'(model_pix(h, v)));
                if (c == 1) rec[h] = dut_pix;
            end
        end
        tgt = (v == VT - 1) ? 0 : v + 1;
        build(tgt);
        k = 0;
        for (int h = HA; h < HA + 80; h++) begin
            h_pos = 10'(h);
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                k++;
                chk("blank_pixel", v, h, 32'(dut_pix), 32'd0);
                if (mode != 1 && (k == 1 || k == 64)) chk("scan_busy_on", v, k, 32'(scan_busy), 32'd1);
                if (mode != 1 && k == 65) chk("scan_busy_off", v, k, 32'(scan_busy), 32'd0);
                if (mode == 2 && k == 10) set_random(int'($urandom_range(0, 470)));
                if (mode == 1 && k == 20) rst = 1'b0;
                if (mode == 1 && k == 24) rst = 1'b1;
            end
        end
        if (mode == 1) begin
            m_list = {}; m_sovf = 1'b0; m_fovf = 1'b0;
        end else begin
            m_list = nl; m_sovf = novf; m_fovf = m_fovf | novf;
        end
        chk("line_count", v, 0, 32'(line_sprite_count), 32'(m_list.size()));
        chk("scan_busy_idle", v, 0, 32'(scan_busy), 32'd0);
`ifdef GPU_SPRITE_OVERFLOW_EN
        chk("sprite_overflow", v, 0, 32'(sprite_overflow), 32'(m_sovf));
        chk("frame_overflow", v, 0, 32'(frame_overflow), 32'(m_fovf));
`endif
    endtask

    task automatic check_vecs(input int scen, input int line);
        foreach (vecs[i])
            if (vecs[i].scen == scen && vecs[i].line == line)
                chk("vec", line, vecs[i].h, 32'(rec[vecs[i].h]),
                    32'({vecs[i].ev, vecs[i].ec, vecs[i].eid}));
    endtask

    initial begin
        vecs = '{
            '{1, 162, 149, 1'b0, 16'h0000, 6'd0}, '{1, 162, 150, 1'b1, 16'hFFFF, 6'd0},
            '{1, 162, 165, 1'b1, 16'hFFFF, 6'd0}, '{1, 162, 166, 1'b0, 16'h0000, 6'd0},
            '{1, 178, 155, 1'b0, 16'h0000, 6'd0},
            '{2, 50, 181, 1'b0, 16'h0000, 6'd0},  '{2, 50, 182, 1'b1, 16'hF800, 6'd5},
            '{2, 50, 190, 1'b1, 16'hF800, 6'd5},  '{2, 50, 197, 1'b1, 16'hF800, 6'd5},
            '{2, 50, 198, 1'b1, 16'h001F, 6'd9},  '{2, 50, 205, 1'b1, 16'h001F, 6'd9},
            '{2, 50, 206, 1'b0, 16'h0000, 6'd0},
            '{3, 100, 25, 1'b1, 16'h0100, 6'd0},  '{3, 100, 300, 1'b1, 16'h0107, 6'd7},
            '{3, 100, 405, 1'b0, 16'h0000, 6'd0}, '{3, 100, 455, 1'b0, 16'h0000, 6'd0},
            '{4, 200, 305, 1'b1, 16'h07E0, 6'd3}, '{4, 200, 335, 1'b0, 16'h0000, 6'd0},
            '{4, 201, 335, 1'b1, 16'h07E0, 6'd3}, '{4, 201, 305, 1'b0, 16'h0000, 6'd0},
            '{5, 0, 25, 1'b1, 16'h1234, 6'd7},
            '{6, 301, 55, 1'b0, 16'h0000, 6'd0},
            '{6, 301, 60, 1'b0, 16'h0000, 6'd0}
        };
        rst = 1'b0; h_pos = '0; v_pos = '0;
        clear_sprites();
        m_sovf = 1'b0; m_fovf = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("reset_valid", 0, 0, 32'(pixel_valid), 32'd0);
        chk("reset_color", 0, 0, 32'(pixel_color), 32'd0);
        chk("reset_id", 0, 0, 32'(pixel_sprite_id), 32'd0);
        chk("reset_busy", 0, 0, 32'(scan_busy), 32'd0);
        chk("reset_count", 0, 0, 32'(line_sprite_count), 32'd0);
        rst = 1'b1;
        run_line(0, 0);

        set_sprite(63, 0, 150, 162, 16'hFFFF);
        run_line(161, 0); run_line(162, 0); check_vecs(1, 162);
        run_line(177, 0); run_line(178, 0); check_vecs(1, 178);

        clear_sprites();
        set_sprite(62, 5, 182, 50, 16'hF800);
        set_sprite(60, 9, 190, 50, 16'h001F);
        run_line(49, 0); run_line(50, 0); check_vecs(2, 50);

        clear_sprites();
        for (int i = 0; i < 10; i++)
            set_sprite(63 - i, i, (i < 8) ? 20 + 40 * i : (i == 8 ? 400 : 450), 100, 16'h0100 + 16'(i));
        run_line(99, 0);
        chk("overflow_count", 99, 0, 32'(line_sprite_count), 32'd8);
        run_line(100, 0); check_vecs(3, 100);

        clear_sprites();
        set_sprite(63, 3, 300, 200, 16'h07E0);
        run_line(199, 0); run_line(200, 3); check_vecs(4, 200);
        run_line(201, 0); check_vecs(4, 201);

        clear_sprites();
        set_sprite(10, 7, 20, 0, 16'h1234);
        run_line(524, 0);
        chk("wrap_count", 524, 0, 32'(line_sprite_count), 32'd1);
        run_line(0, 0); check_vecs(5, 0);

        clear_sprites();
        set_sprite(63, 2, 50, 301, 16'hABCD);
        run_line(300, 1);
        chk("rst_mid_count", 300, 0, 32'(line_sprite_count), 32'd0);
        run_line(301, 0); check_vecs(6, 301);

        set_random(251);
        run_line(250, 2); run_line(251, 0);

        for (int i = 0; i < 10; i++) begin
            int v, nxt;
            v = (i == 3) ? 524 : (i == 5) ? 479 : int'($urandom_range(0, 478));
            nxt = (v == VT - 1) ? 0 : v + 1;
            set_random(nxt);
            run_line(v, 0);
            run_line(nxt, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
